// File: rtl/pixel_pkg.sv
// Shared pixel-path types and heat-map thresholds.
// Used by the gray-to-heatmap colouriser and its testbench.
package pixel_pkg;

    localparam int GRAY_W_DEF = 8;

    typedef struct packed {
        logic [GRAY_W_DEF-1:0] gray;
        logic                  sof;
        logic                  eol;
    } pixel_t;

    typedef struct packed {
        logic [GRAY_W_DEF-1:0] r;
        logic [GRAY_W_DEF-1:0] g;
        logic [GRAY_W_DEF-1:0] b;
    } rgb_t;

    function automatic int maxv_of(input int w);
        return (1 << w) - 1;
    endfunction

    // Red saturates at the low threshold, green at the high one.
    function automatic int heat_lo(input int maxv);
        return maxv;
    endfunction

    function automatic int heat_hi(input int maxv);
        return 2 * maxv;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready register slice; accepts whenever it is empty
// or its content leaves downstream in the same cycle.
module pipe_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/gray_heatmap_colorizer.sv
// Two-stage gray -> black/red/yellow/white heat-map colouriser.
// HEATMAP_INVERT_EN adds a per-beat invert input.
module gray_heatmap_colorizer
    import pixel_pkg::*;
#(
    parameter int GRAY_W      = GRAY_W_DEF,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [GRAY_W-1:0]      in_gray,
    input  logic                   in_sof,
    input  logic                   in_eol,
`ifdef HEATMAP_INVERT_EN
    input  logic                   invert,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [GRAY_W-1:0]      out_r,
    output logic [GRAY_W-1:0]      out_g,
    output logic [GRAY_W-1:0]      out_b,
    output logic                   out_sof,
    output logic                   out_eol,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int TW   = GRAY_W + 2;
    localparam int MAXV = maxv_of(GRAY_W);
    localparam int S1W  = TW + 2;
    localparam int S2W  = 3 * GRAY_W + 2;

    localparam logic [TW-1:0]     LO_T   = TW'(heat_lo(MAXV));
    localparam logic [TW-1:0]     HI_T   = TW'(heat_hi(MAXV));
    localparam logic [GRAY_W-1:0] MAXV_G = GRAY_W'(MAXV);

    logic [GRAY_W-1:0] gray_eff;
    logic [TW-1:0]     t_d;
    logic [S1W-1:0]    s1_in;
    logic [S1W-1:0]    s1_data;
    logic              s1_valid;
    logic              s2_ready;

    logic [TW-1:0]     s1_t;
    logic              s1_sof;
    logic              s1_eol;
    logic [TW-1:0]     g_t;
    logic [TW-1:0]     b_t;
    logic [GRAY_W-1:0] r_d;
    logic [GRAY_W-1:0] g_d;
    logic [GRAY_W-1:0] b_d;
    logic [S2W-1:0]    s2_in;
    logic [S2W-1:0]    s2_data;

    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_d;

`ifdef HEATMAP_INVERT_EN
    assign gray_eff = invert ? (MAXV_G - in_gray) : in_gray;
`else
    assign gray_eff = in_gray;
`endif

    // 3*g as g + 2*g, wide enough for 3*MAXV.
    assign t_d   = {2'b00, gray_eff} + {1'b0, gray_eff, 1'b0};
    assign s1_in = {t_d, in_sof, in_eol};

    pipe_stage_reg #(
        .W (S1W)
    ) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_data)
    );

    assign {s1_t, s1_sof, s1_eol} = s1_data;

    always_comb begin
        g_t = s1_t - LO_T;
        b_t = s1_t - HI_T;
        r_d = (s1_t >= LO_T) ? MAXV_G : s1_t[GRAY_W-1:0];
        g_d = '0;
        b_d = '0;
        if (s1_t > LO_T) begin
            g_d = (s1_t >= HI_T) ? MAXV_G : g_t[GRAY_W-1:0];
        end
        if (s1_t > HI_T) begin
            b_d = b_t[GRAY_W-1:0];
        end
    end

    assign s2_in = {r_d, g_d, b_d, s1_sof, s1_eol};

    pipe_stage_reg #(
        .W (S2W)
    ) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_data)
    );

    assign {out_r, out_g, out_b, out_sof, out_eol} = s2_data;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (out_valid && out_ready && out_sof) begin
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_gray_heatmap_colorizer.sv
// Directed bench for gray_heatmap_colorizer: mapping, ramp, stall,
// sideband/frame count, reset mid-stream and optional invert.
module tb_gray_heatmap_colorizer;
    import pixel_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_gray = '0;
    logic       in_sof = 1'b0;
    logic       in_eol = 1'b0;
    logic       out_ready = 1'b1;
`ifdef HEATMAP_INVERT_EN
    logic       invert = 1'b0;
`endif

    logic        in_ready, out_valid, out_sof, out_eol;
    logic [7:0]  out_r, out_g, out_b;
    logic [15:0] frame_cnt;

    logic        s_in_ready, s_out_valid, s_out_sof, s_out_eol;
    logic [7:0]  s_out_r, s_out_g, s_out_b;
    logic [1:0]  s_frame_cnt;

    always #5 clk = ~clk;

    gray_heatmap_colorizer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_gray   (in_gray),
        .in_sof    (in_sof),
        .in_eol    (in_eol),
`ifdef HEATMAP_INVERT_EN
        .invert    (invert),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_g     (out_g),
        .out_b     (out_b),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .frame_cnt (frame_cnt)
    );

    gray_heatmap_colorizer #(
        .FRAME_CNT_W (2)
    ) dut_small (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .in_gray   (in_gray),
        .in_sof    (in_sof),
        .in_eol    (in_eol),
`ifdef HEATMAP_INVERT_EN
        .invert    (invert),
`endif
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_r     (s_out_r),
        .out_g     (s_out_g),
        .out_b     (s_out_b),
        .out_sof   (s_out_sof),
        .out_eol   (s_out_eol),
        .frame_cnt (s_frame_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_rx     = 0;
    int n_stall  = 0;
    bit mon_en   = 1'b0;
    logic [25:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic rgb_t heat_ref(input int g, input bit inv);
        rgb_t c;
        int   v;
        int   t;
        v = inv ? 255 - g : g;
        t = 3 * v;
        c.r = (t > 255) ? 8'd255 : 8'(t);
        c.g = (t <= 255) ? 8'd0 : (t >= 510) ? 8'd255 : 8'(t - 255);
        c.b = (t <= 510) ? 8'd0 : 8'(t - 510);
        return c;
    endfunction

    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(exp_q.size()), 32'd1);
            end else begin
                check("stream", 32'({out_r, out_g, out_b, out_sof, out_eol}),
                      32'(exp_q.pop_front()));
            end
            n_rx++;
        end
    end

    task automatic send(input int g, input bit sof, input bit eol,
                        input bit inv);
        int k;
        in_valid = 1'b1;
        in_gray  = 8'(g);
        in_sof   = sof;
        in_eol   = eol;
`ifdef HEATMAP_INVERT_EN
        invert   = inv;
`endif
        k = 0;
        @(negedge clk);
        if (!in_ready) n_stall++;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        exp_q.push_back({heat_ref(g, inv), sof, eol});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eol   = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 500) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sw_gray[6];
        logic [23:0] sw_rgb[6];
        logic [25:0] cap;
        int          rx0;
        int          seen;

        sw_gray = '{0, 85, 100, 170, 200, 255};
        sw_rgb  = '{24'h000000, 24'hff0000, 24'hff2d00,
                    24'hffff00, 24'hffff5a, 24'hffffff};

        do_reset();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_rgb", 32'({out_r, out_g, out_b}), 32'd0);
        check("rst_side", 32'({out_sof, out_eol}), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_gray  = 8'(sw_gray[i]);
            @(negedge clk);
            check("sw_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(negedge clk);
            check("sw_lat_early", 32'(out_valid), 32'd0);
            @(negedge clk);
            check("sw_lat_valid", 32'(out_valid), 32'd1);
            check("sw_rgb", 32'({out_r, out_g, out_b}), 32'(sw_rgb[i]));
            @(posedge clk);
            #1;
        end

        mon_en  = 1'b1;
        rx0     = n_rx;
        n_stall = 0;
        for (int g = 0; g < 256; g++) send(g, 1'b0, 1'b0, 1'b0);
        drain();
        check("ramp_count", 32'(n_rx - rx0), 32'd256);
        check("ramp_no_stall", 32'(n_stall), 32'd0);

        rx0 = n_rx;
        fork
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                check("bp_in_ready", 32'(in_ready), 32'd0);
                check("bp_out_valid", 32'(out_valid), 32'd1);
                cap = {out_r, out_g, out_b, out_sof, out_eol};
                repeat (2) @(negedge clk);
                check("bp_stable", 32'({out_r, out_g, out_b, out_sof, out_eol}),
                      32'(cap));
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 10; i++) send(i * 25 + 3, 1'b0, 1'b0, 1'b0);
            end
        join
        drain();
        check("bp_count", 32'(n_rx - rx0), 32'd10);

        do_reset();
        for (int f = 0; f < 3; f++)
            for (int p = 0; p < 64; p++)
                send((f * 64 + p) & 255, p == 0, p == 63, 1'b0);
        drain();
        check("frame_cnt_3", 32'(frame_cnt), 32'd3);
        check("frame_cnt_w2_3", 32'(s_frame_cnt), 32'd3);
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < 64; p++)
                send((p * 3) & 255, p == 0, p == 63, 1'b0);
        drain();
        check("frame_cnt_5", 32'(frame_cnt), 32'd5);
        check("frame_cnt_w2_wrap", 32'(s_frame_cnt), 32'd1);

        mon_en   = 1'b0;
        in_valid = 1'b1;
        in_gray  = 8'd10;
        in_sof   = 1'b1;
        @(posedge clk);
        #1;
        in_gray  = 8'd20;
        in_sof   = 1'b0;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_rel_in_ready", 32'(in_ready), 32'd1);
        check("rst_rel_out_valid", 32'(out_valid), 32'd0);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_no_stale", 32'(seen), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);

`ifdef HEATMAP_INVERT_EN
        exp_q.delete();
        mon_en = 1'b1;
        rx0 = n_rx;
        send(0, 1'b0, 1'b0, 1'b1);
        send(85, 1'b0, 1'b0, 1'b1);
        send(100, 1'b0, 1'b0, 1'b0);
        send(200, 1'b0, 1'b0, 1'b0);
        drain();
        check("inv_count", 32'(n_rx - rx0), 32'd4);
        in_valid = 1'b1;
        in_gray  = 8'd85;
        invert   = 1'b1;
        mon_en   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        invert   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("inv_85_rgb", 32'({out_r, out_g, out_b}), 32'h00ffff00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_heatmap_colorizer.md
Name: gray_heatmap_colorizer

Overview:
- Streaming converter from an 8-bit grayscale pixel to a 24-bit RGB false-colour "heat" pixel: black, then red, then yellow, then white.
- This is the inverse-direction counterpart of the pixel path's RGB-to-gray converter. It feeds display and debug overlays from gray-domain processing results.
- Two-stage registered pipeline with valid/ready handshake, full backpressure support, and frame sideband pass-through.

Parameters:
- GRAY_W, 8: grayscale/channel width. Let MAXV = 2^GRAY_W - 1. All thresholds derive from MAXV.
- FRAME_CNT_W, 16: width of the completed-frame counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_gray  in  GRAY_W  grayscale pixel
- in_sof  in  1  first pixel of frame (sideband, passed through)
- in_eol  in  1  last pixel of line (sideband, passed through)
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_r / out_g / out_b  out  GRAY_W each  colour channels
- out_sof / out_eol  out  1 each  delayed sideband
- frame_cnt  out  FRAME_CNT_W  count of sof beats emitted at output

Behaviour:
- Reset (async assert, sync-safe release): s1_valid=0, s2_valid=0, out_valid=0, out_r/g/b=0, out_sof/eol=0, frame_cnt=0. Data registers may also clear to 0; they must clear if no enable is used.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Stage 1 (S1) registers t = 3*in_gray, GRAY_W+2 bits (max 3*MAXV, no overflow), plus sof/eol.
- Stage 2 (S2) registers the colour from t, using unsigned compares only:
  - R = (t >= MAXV) ? MAXV : t
  - G = (t <= MAXV) ? 0 : (t >= 2*MAXV) ? MAXV : t - MAXV
  - B = (t <= 2*MAXV) ? 0 : t - 2*MAXV
  - Each result is truncated to GRAY_W; it is always in range by construction.
- Advance rules:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv, purely combinational from out_ready and valid flags (no comb path from in_valid).
- Latency: exactly 2 cycles from input transfer to out_valid when out_ready is held high. Throughput is 1 beat/cycle.
- Backpressure: with out_ready low, S2 holds its data stable and out_valid stays high.
  - S1 fills, then in_ready drops.
  - No beat is lost or duplicated. Output order equals input order.
- Bubbles: S1 loads s1_valid <= in_valid && in_ready whenever s1_adv. Empty stages are overwritten freely.
- Simultaneous output transfer and input transfer with a full pipe: all stages shift in the same cycle, and in_ready stays high.
- frame_cnt increments on each output transfer with out_sof=1. It wraps at 2^FRAME_CNT_W - 1 to 0 silently.
- Reset mid-stream: in-flight beats are discarded, with no partial output. in_ready is 1 on the first cycle after release.
- No internal state machine beyond the per-stage valid flags.

Optional Feature:
- Macro HEATMAP_INVERT_EN.
- Defined: adds input port invert (1 bit), sampled with each input transfer. When 1, S1 uses MAXV - in_gray in place of in_gray, so white maps to black-end colour and vice versa. The value is per-beat and carries no state.
- Undefined: the port is absent and the mapping uses in_gray directly. Timing and latency are identical in both builds.

Decomposition:
- Shared package pixel_pkg holds:
  - GRAY_W default constant
  - the pixel struct/typedef (gray, sof, eol)
  - the rgb_t typedef (r, g, b)
  - heat thresholds expressed as functions of MAXV
- One natural sub-module: pipe_stage_reg, a generic valid/ready register slice with data width parameter, instantiated twice. Colour math stays in the top module.

Test Plan:
- Mapping sweep, out_ready=1, in_gray = 0, 85, 100, 170, 200, 255 -> RGB equals (0,0,0), (255,0,0), (255,45,0), (255,255,0), (255,255,90), (255,255,255), each exactly 2 cycles after acceptance.
- Full 0..255 ramp, back-to-back -> 256 outputs in order, each matching the reference formula. One beat per cycle sustained, and in_ready never drops.
- Backpressure: stream 10 pixels with out_ready low for cycles 3-8.
  - in_ready falls after 2 beats are buffered.
  - Output data is stable while stalled.
  - All 10 pixels arrive in order with no loss or duplication.
- Sideband: sof on pixel 0 and eol on pixel 63 of 3 frames -> out_sof/out_eol aligned with the same pixels, and frame_cnt = 3. With FRAME_CNT_W=2, 5 frames -> frame_cnt = 1.
- Reset mid-stream: assert rst asynchronously with 2 beats in flight -> out_valid=0 immediately. No stale output after release, and in_ready=1 on the first cycle after release.
- HEATMAP_INVERT_EN build: in_gray=0 with invert=1 -> (255,255,255); in_gray=85 with invert=1 -> t=510 -> (255,255,0); invert=0 -> results identical to the base mapping.
